// File: rtl/multi_cycle_control_if.sv
// rtl/multi_cycle_control_if.sv - control bundle between the multi-cycle controller and its datapath
interface multi_cycle_control_if;
   logic [5:0] Opcode;
   logic       MemReady;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemToReg;
   logic       RegWrite;
   logic       RegDst;
   logic       ALUSrcA;
   logic       SignExtend;
   logic [1:0] PCSource;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUOp;
   logic       InstrDone;
   logic       Illegal;
   logic [3:0] State;

   modport master (
      output Opcode, MemReady,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
             RegWrite, RegDst, ALUSrcA, SignExtend, PCSource, ALUSrcB, ALUOp,
             InstrDone, Illegal, State
   );

   modport slave (
      input  Opcode, MemReady,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
             RegWrite, RegDst, ALUSrcA, SignExtend, PCSource, ALUSrcB, ALUOp,
             InstrDone, Illegal, State
   );
endinterface

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle MIPS control FSM; MEM_WAIT_EN enables MemReady stretching
module multi_cycle_control (
   input  logic                  CLK,
   input  logic                  Reset_L,
   multi_cycle_control_if.slave  bus
);
   localparam logic [3:0] S_START  = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_RWB    = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JUMP   = 4'd10;
   localparam logic [3:0] S_IEXEC  = 4'd11;
   localparam logic [3:0] S_IWB    = 4'd12;
   localparam logic [3:0] S_TRAP   = 4'd15;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_ADDU = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_LUI  = 4'b1110;
   localparam logic [3:0] OP_FUNC = 4'b1111;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [5:0] r_opreg;
   logic       r_illegal;
   logic       w_mem_done;
   logic [3:0] w_imm_aluop;
   logic       w_imm_sx;

`ifdef MEM_WAIT_EN
   assign w_mem_done = bus.MemReady;
`else
   // MemReady is read but has no effect: every access completes at once
   assign w_mem_done = 1'b1 | bus.MemReady;
`endif

   always_comb begin
      w_next = S_START;
      case (r_state)
         S_START:  w_next = S_FETCH;
         S_FETCH:  w_next = w_mem_done ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Opcode)
               6'b100011, 6'b101011: w_next = S_MEMADR;
               6'b000000:            w_next = S_EXEC;
               6'b000100:            w_next = S_BRANCH;
               6'b000010:            w_next = S_JUMP;
               6'b001000, 6'b001001, 6'b001100, 6'b001101,
               6'b001010, 6'b001011, 6'b001110, 6'b001111: w_next = S_IEXEC;
               default:              w_next = S_TRAP;
            endcase
         end
         S_MEMADR: w_next = (r_opreg == 6'b101011) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  w_next = w_mem_done ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = w_mem_done ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = S_RWB;
         S_IEXEC:  w_next = S_IWB;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: w_next = S_FETCH;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_START;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state   <= S_START;
         r_opreg   <= 6'd0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opreg <= bus.Opcode;
            if (w_next == S_TRAP)
               r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_imm_aluop = OP_ADD;
      w_imm_sx    = 1'b0;
      case (r_opreg)
         6'b001000: begin w_imm_aluop = OP_ADD;  w_imm_sx = 1'b1; end
         6'b001001: begin w_imm_aluop = OP_ADDU; w_imm_sx = 1'b0; end
         6'b001100: begin w_imm_aluop = OP_AND;  w_imm_sx = 1'b0; end
         6'b001101: begin w_imm_aluop = OP_OR;   w_imm_sx = 1'b0; end
         6'b001110: begin w_imm_aluop = OP_XOR;  w_imm_sx = 1'b0; end
         6'b001111: begin w_imm_aluop = OP_LUI;  w_imm_sx = 1'b0; end
         6'b001010: begin w_imm_aluop = OP_SLT;  w_imm_sx = 1'b1; end
         6'b001011: begin w_imm_aluop = OP_SLTU; w_imm_sx = 1'b1; end
         default:   begin w_imm_aluop = OP_ADD;  w_imm_sx = 1'b0; end
      endcase
   end

   // Moore strobes; only the completion-gated ones look at w_mem_done
   always_comb begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemToReg    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.SignExtend  = 1'b0;
      bus.PCSource    = 2'b00;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = OP_ADD;
      bus.InstrDone   = 1'b0;
      case (r_state)
         S_START, S_TRAP: bus.ALUOp = 4'b0000;
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = w_mem_done;
            bus.PCWrite = w_mem_done;
         end
         S_DECODE: begin
            bus.ALUSrcB    = 2'b11;
            bus.SignExtend = 1'b1;
         end
         S_MEMADR: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUSrcB    = 2'b10;
            bus.SignExtend = 1'b1;
         end
         S_MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.RegWrite  = 1'b1;
            bus.MemToReg  = 1'b1;
            bus.InstrDone = 1'b1;
         end
         S_MEMWR: begin
            bus.MemWrite  = 1'b1;
            bus.IorD      = 1'b1;
            bus.InstrDone = w_mem_done;
         end
         S_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = OP_FUNC;
         end
         S_RWB: begin
            bus.RegDst    = 1'b1;
            bus.RegWrite  = 1'b1;
            bus.InstrDone = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = OP_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
            bus.InstrDone   = 1'b1;
         end
         S_JUMP: begin
            bus.PCWrite   = 1'b1;
            bus.PCSource  = 2'b10;
            bus.InstrDone = 1'b1;
         end
         S_IEXEC: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUSrcB    = 2'b10;
            bus.ALUOp      = w_imm_aluop;
            bus.SignExtend = w_imm_sx;
         end
         S_IWB: begin
            bus.ALUOp      = w_imm_aluop;
            bus.SignExtend = w_imm_sx;
            bus.RegWrite   = 1'b1;
            bus.InstrDone  = 1'b1;
         end
         default: bus.ALUOp = 4'b0000;
      endcase
   end

   assign bus.Illegal = r_illegal;
   assign bus.State   = r_state;
endmodule
